// File: rtl/skip_subtractor_seq_pkg.sv
// rtl/skip_subtractor_seq_pkg.sv - shared constants, FSM state type and slice-count helper
package skip_sub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_slices(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/skip_subtractor_seq_if.sv
// rtl/skip_subtractor_seq_if.sv - operand/result handshake bundle; ovf present only with SKIP_SUB_OVF_EN
interface skip_subtractor_seq_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SKIP_SUB_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
`endif

endinterface

// File: rtl/skip_subtractor_seq_slice.sv
// rtl/skip_subtractor_seq_slice.sv - combinational 4-bit carry-skip slice of a + ~b + cin
module skip_sub_slice
  import skip_sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               cin,
  output logic [SLICE_W-1:0] d4,
  output logic               cout,
  output logic               skip,
  output logic               cmsb
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   c;

  assign p = a4 ^ ~b4;
  assign g = a4 & ~b4;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  // Sum bits always ripple; only the slice carry-out is bypassed when every bit propagates.
  assign d4   = p ^ c[SLICE_W-1:0];
  assign skip = &p;
  assign cout = skip ? cin : c[SLICE_W];
  assign cmsb = c[SLICE_W-1];

endmodule

// File: rtl/skip_subtractor_seq.sv
// rtl/skip_subtractor_seq.sv - slice-serial a - b - bin, one 4-bit slice per clock
// Optional signed-overflow output enabled by defining SKIP_SUB_OVF_EN.
module skip_subtractor_seq
  import skip_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  skip_subtractor_seq_if.slave bus
);

  localparam int N     = num_slices(WIDTH);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   diff_r;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               bout_r;
  logic               in_ready_r;
  logic               out_valid_r;

  logic [SLICE_W-1:0] a4;
  logic [SLICE_W-1:0] b4;
  logic [SLICE_W-1:0] d4;
  logic               slice_cout;
  logic               slice_skip;
  logic               slice_cmsb;

  assign a4 = a_r[idx*SLICE_W +: SLICE_W];
  assign b4 = b_r[idx*SLICE_W +: SLICE_W];

  // One slice instance, time-multiplexed across the operand by idx.
  skip_sub_slice u_slice (
    .a4   (a4),
    .b4   (b4),
    .cin  (carry),
    .d4   (d4),
    .cout (slice_cout),
    .skip (slice_skip),
    .cmsb (slice_cmsb)
  );

`ifdef SKIP_SUB_OVF_EN
  logic ovf_r;
  logic unused_slice_bits;

  assign unused_slice_bits = slice_skip;
  assign bus.ovf           = ovf_r;
`else
  logic unused_slice_bits;

  assign unused_slice_bits = slice_skip ^ slice_cmsb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      diff_r      <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      bout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef SKIP_SUB_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            carry      <= ~bus.bin;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          diff_r[idx*SLICE_W +: SLICE_W] <= d4;
          carry                          <= slice_cout;
          if (idx == LAST_IDX) begin
            bout_r      <= ~slice_cout;
`ifdef SKIP_SUB_OVF_EN
            ovf_r       <= slice_cmsb ^ slice_cout;
`endif
            idx         <= '0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Return to IDLE only; the next accept waits a cycle for in_ready.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.diff      = diff_r;
  assign bus.bout      = bout_r;

endmodule

// File: tb/tb_skip_subtractor_seq.sv
// tb/tb_skip_subtractor_seq.sv - directed bench with reference model for skip_subtractor_seq at WIDTH=16
module tb_skip_subtractor_seq;

  logic clk;
  logic rst_n;

  skip_subtractor_seq_if #(.WIDTH(16)) bus ();

  skip_subtractor_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] m_diff(input logic [15:0] x, input logic [15:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return r[15:0];
  endfunction

  function automatic logic m_bout(input logic [15:0] x, input logic [15:0] y, input logic c);
    return int'(x) < (int'(y) + int'(c));
  endfunction

  function automatic logic m_ovf(input logic [15:0] x, input logic [15:0] y, input logic c);
    int sx;
    int sy;
    int r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = sx - sy - int'(c);
    return (r < -32768) || (r > 32767);
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        check("cmp_diff", 32'(bus.diff), 32'(exp_q[0].d));
        check("cmp_bout", 32'(bus.bout), 32'(exp_q[0].bo));
`ifdef SKIP_SUB_OVF_EN
        check("cmp_ovf", 32'(bus.ovf), 32'(exp_q[0].ov));
`endif
        check("cmp_in_ready_low", 32'(bus.in_ready), 32'd0);
      end
    end
  end

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                        input int hold, input bit glitch,
                        input logic [15:0] lit_d, input logic lit_b, input logic lit_o);
    int   k;
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.a        = ta;
    bus.b        = tb_v;
    bus.bin      = tbin;
    bus.in_valid = 1'b1;
    e.d  = m_diff(ta, tb_v, tbin);
    e.bo = m_bout(ta, tb_v, tbin);
    e.ov = m_ovf(ta, tb_v, tbin);
    @(posedge clk);
    exp_q.push_back(e);
    k = 0;
    forever begin
      @(negedge clk);
      bus.in_valid = glitch && (k == 1);
      bus.a        = ~ta;
      bus.b        = ~tb_v;
      bus.bin      = ~tbin;
      if (bus.out_valid || k >= 20) break;
      k++;
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(k), 32'd4);
    repeat (hold) begin
      @(negedge clk);
      check("held_valid", 32'(bus.out_valid), 32'd1);
    end
    check("lit_diff", 32'(bus.diff), 32'(lit_d));
    check("lit_bout", 32'(bus.bout), 32'(lit_b));
`ifdef SKIP_SUB_OVF_EN
    check("lit_ovf", 32'(bus.ovf), 32'(lit_o));
`else
    if (lit_o !== 1'b0 && lit_o !== 1'b1) check("lit_ovf_arg", 32'(lit_o), 32'd0);
`endif
    bus.out_ready = 1'b1;
    @(posedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_dropped", 32'(bus.out_valid), 32'd0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SKIP_SUB_OVF_EN
    check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0034, 1'b0, 0, 1'b0, 16'h1200, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h5A5A, 16'h5A5A, 1'b1, 0, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0, 16'h8000, 1'b1, 1'b1);
    run_op(16'hABCD, 16'h1234, 1'b0, 5, 1'b1, 16'h9999, 1'b0, 1'b0);

    // Abort during the second BUSY cycle; low nibble already holds a partial slice.
    @(negedge clk);
    bus.a        = 16'h1111;
    bus.b        = 16'h0222;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_bout", 32'(bus.bout), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("abort_no_result", 32'(bus.out_valid), 32'd0);
    end
    check("abort_idle_ready", 32'(bus.in_ready), 32'd1);

    run_op(16'h0010, 16'h0001, 1'b0, 0, 1'b0, 16'h000F, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
